// File: rtl/train_balancer_pkg.sv
// Shared types and constants for the multi-channel dropoff station.
// Quotients from the shared divider saturate, and a zero divisor yields zero.
package train_balancer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_DIV_S,
      ST_DIV_T7,
      ST_DIV_T8,
      ST_COMMIT,
      ST_DONE
   } state_e;

   localparam int DEF_CH  = 4;
   localparam int DEF_INT = 31;

   localparam logic [DEF_INT:0] DZ_QUOTIENT  = '0;
   localparam logic [DEF_INT:0] SAT_QUOTIENT = '1;

   function automatic int div_cycles(input int int_msb);
      return 2 * int_msb + 3;
   endfunction

   // Cycles from the tick-sampling edge to the cycle in which valid is high.
   function automatic int sweep_cycles(input int ch, input int int_msb);
      return ch * (3 * div_cycles(int_msb) + 2) + 1;
   endfunction

endpackage

// File: rtl/multi_dropoff_station_seq_divider.sv
// Restoring divider: one load cycle, then DW iterations; done is high in the last one.
// The quotient saturates to all ones and is forced to zero on a zero divisor.
module seq_divider #(
   parameter int DW = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DW-1:0]     dividend,
   input  logic [DW/2-1:0]   divisor,
   output logic              done,
   output logic [DW/2-1:0]   quotient,
   output logic              dz
);

   localparam int QW = DW / 2;
   localparam int CW = $clog2(DW + 1);

   logic          run_q, run_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rem_q, rem_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [QW-1:0] den_q, den_d;
   logic          dz_q, dz_d;

   logic [DW:0]   shifted;
   logic [DW:0]   diff;
   logic [DW-1:0] rem_step;
   logic [DW-1:0] quo_step;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      shifted = {rem_q, quo_q[DW-1]};
      diff    = shifted - {{(QW + 1){1'b0}}, den_q};
      if (!diff[DW]) begin
         rem_step = diff[DW-1:0];
         quo_step = {quo_q[DW-2:0], 1'b1};
      end else begin
         rem_step = shifted[DW-1:0];
         quo_step = {quo_q[DW-2:0], 1'b0};
      end

      run_d = run_q;
      cnt_d = cnt_q;
      rem_d = rem_q;
      quo_d = quo_q;
      den_d = den_q;
      dz_d  = dz_q;

      if (run_q) begin
         rem_d = rem_step;
         quo_d = quo_step;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            run_d = 1'b0;
         end
      end else if (start) begin
         rem_d = '0;
         quo_d = dividend;
         den_d = divisor;
         dz_d  = (divisor == '0);
         cnt_d = CW'(DW);
         run_d = 1'b1;
      end

      done = run_q && (cnt_q == CW'(1));
      if (dz_q) begin
         quotient = '0;
      end else if (|quo_step[DW-1:QW]) begin
         quotient = '1;
      end else begin
         quotient = quo_step[QW-1:0];
      end
   end

   assign dz = dz_q;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         den_q <= '0;
         dz_q  <= 1'b0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         den_q <= den_d;
         dz_q  <= dz_d;
      end
   end

endmodule

// File: rtl/multi_dropoff_station.sv
// Multi-channel dropoff station: snapshots inputs on tick, sweeps the channels
// through one shared divider, and publishes all S/L results together.
module multi_dropoff_station
   import train_balancer_pkg::*;
#(
   parameter int CH  = 4,
   parameter int INT = 31
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic [INT:0]          p,
   input  logic [INT:0]          g,
   input  logic [CH*(INT+1)-1:0] r,
   input  logic [CH*(INT+1)-1:0] u,
   input  logic [CH*(INT+1)-1:0] c,
   input  logic [CH*(INT+1)-1:0] t,
   input  logic [CH*(INT+1)-1:0] cfg_q,
   input  logic [CH*(INT+1)-1:0] cfg_m,
   input  logic [CH*(INT+1)-1:0] cfg_w,
   output logic [CH*(INT+1)-1:0] s,
   output logic [CH*(INT+1)-1:0] l,
   output logic                  valid,
   output logic                  busy,
   output logic                  overrun,
   output logic [CH-1:0]         div0
);

   localparam int W  = INT + 1;
   localparam int VW = CH * W;
   localparam int IW = (CH > 1) ? $clog2(CH) : 1;

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;

   logic [INT:0]  p_sh_q, p_sh_d, g_sh_q, g_sh_d;
   logic [VW-1:0] r_sh_q, r_sh_d, u_sh_q, u_sh_d, c_sh_q, c_sh_d, t_sh_q, t_sh_d;
   logic [VW-1:0] qlen_sh_q, qlen_sh_d, m_sh_q, m_sh_d, w_sh_q, w_sh_d;

   logic [INT:0]  a_q, a_d, s_val_q, s_val_d, t7_q, t7_d, t8_q, t8_d;
   logic          b_q, b_d, e_q, e_d, g_dz_q, g_dz_d, dz_acc_q, dz_acc_d;

   logic [VW-1:0] s_buf_q, s_buf_d, l_buf_q, l_buf_d;
   logic [CH-1:0] dz_buf_q, dz_buf_d;

   logic [VW-1:0] s_out_q, s_out_d, l_out_q, l_out_d;
   logic [CH-1:0] div0_q, div0_d;
   logic          valid_q, valid_d, busy_q, busy_d, overrun_q, overrun_d;

   logic [INT:0]  r_k, u_k, c_k, t_k, qlen_k, m_k, w_k;
   logic          t0;
   logic [INT:0]  z, zw, a_calc;
   logic          b_calc, e_calc, d_flag;
   logic [INT:0]  mul_a, l_new;
   logic [2*W-1:0] prod;

   logic          div_start, div_done, div_dz;
   logic [2*W-1:0] div_dividend;
   logic [INT:0]  div_divisor, div_quot;

   assign r_k    = r_sh_q[idx_q*W +: W];
   assign u_k    = u_sh_q[idx_q*W +: W];
   assign c_k    = c_sh_q[idx_q*W +: W];
   assign t_k    = t_sh_q[idx_q*W +: W];
   assign qlen_k = qlen_sh_q[idx_q*W +: W];
   assign m_k    = m_sh_q[idx_q*W +: W];
   assign w_k    = w_sh_q[idx_q*W +: W];

   // Trains still inbound exclude the one already present; never below zero.
   assign t0     = (t_k != '0);
   assign z      = (t0 && (c_k == '0)) ? '0 : c_k - {{INT{1'b0}}, t0};
   assign zw     = z * w_k;
   assign a_calc = u_k + zw;
   assign b_calc = (a_calc < m_k) && ((m_k - a_calc) >= w_k);
   assign e_calc = (c_k < qlen_k);

   // One multiplier serves both A*P and R*P.
   assign mul_a  = (state_q == ST_DIV_S) ? a_q : r_k;
   assign prod   = {{W{1'b0}}, mul_a} * {{W{1'b0}}, p_sh_q};

   assign d_flag = (s_val_q <= t8_q) && !g_dz_q;
   assign l_new  = c_k + {{INT{1'b0}}, (b_q && d_flag && e_q)};

   always_comb begin
      div_start    = 1'b0;
      div_dividend = prod;
      div_divisor  = m_k;
      case (state_q)
         ST_DIV_S:  div_start = 1'b1;
         ST_DIV_T7: begin
            div_start   = 1'b1;
            div_divisor = g_sh_q;
         end
         ST_DIV_T8: begin
            div_start    = 1'b1;
            div_dividend = {{W{1'b0}}, t7_q};
            div_divisor  = p_sh_q;
         end
         default: ;
      endcase
   end

   seq_divider #(
      .DW(2 * W)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .done     (div_done),
      .quotient (div_quot),
      .dz       (div_dz)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      p_sh_d    = p_sh_q;
      g_sh_d    = g_sh_q;
      r_sh_d    = r_sh_q;
      u_sh_d    = u_sh_q;
      c_sh_d    = c_sh_q;
      t_sh_d    = t_sh_q;
      qlen_sh_d = qlen_sh_q;
      m_sh_d    = m_sh_q;
      w_sh_d    = w_sh_q;
      a_d       = a_q;
      b_d       = b_q;
      e_d       = e_q;
      s_val_d   = s_val_q;
      t7_d      = t7_q;
      t8_d      = t8_q;
      g_dz_d    = g_dz_q;
      dz_acc_d  = dz_acc_q;
      s_buf_d   = s_buf_q;
      l_buf_d   = l_buf_q;
      dz_buf_d  = dz_buf_q;
      s_out_d   = s_out_q;
      l_out_d   = l_out_q;
      div0_d    = div0_q;
      valid_d   = 1'b0;
      overrun_d = tick && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               p_sh_d    = p;
               g_sh_d    = g;
               r_sh_d    = r;
               u_sh_d    = u;
               c_sh_d    = c;
               t_sh_d    = t;
               qlen_sh_d = cfg_q;
               m_sh_d    = cfg_m;
               w_sh_d    = cfg_w;
               idx_d     = '0;
               state_d   = ST_CALC;
            end
         end
         ST_CALC: begin
            a_d      = a_calc;
            b_d      = b_calc;
            e_d      = e_calc;
            dz_acc_d = 1'b0;
            state_d  = ST_DIV_S;
         end
         ST_DIV_S: begin
            if (div_done) begin
               s_val_d  = div_quot;
               dz_acc_d = dz_acc_q | div_dz;
               state_d  = ST_DIV_T7;
            end
         end
         ST_DIV_T7: begin
            if (div_done) begin
               t7_d     = div_quot;
               g_dz_d   = div_dz;
               dz_acc_d = dz_acc_q | div_dz;
               state_d  = ST_DIV_T8;
            end
         end
         ST_DIV_T8: begin
            if (div_done) begin
               t8_d     = div_quot;
               dz_acc_d = dz_acc_q | div_dz;
               state_d  = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            s_buf_d[idx_q*W +: W] = s_val_q;
            l_buf_d[idx_q*W +: W] = l_new;
            dz_buf_d[idx_q]       = dz_acc_q;
            if (idx_q == IW'(CH - 1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = ST_CALC;
            end
         end
         ST_DONE: begin
            s_out_d = s_buf_q;
            l_out_d = l_buf_q;
            div0_d  = dz_buf_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // NOTE: snapshot and result buffers are reset too, so outputs read 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         p_sh_q    <= '0;
         g_sh_q    <= '0;
         r_sh_q    <= '0;
         u_sh_q    <= '0;
         c_sh_q    <= '0;
         t_sh_q    <= '0;
         qlen_sh_q <= '0;
         m_sh_q    <= '0;
         w_sh_q    <= '0;
         a_q       <= '0;
         b_q       <= 1'b0;
         e_q       <= 1'b0;
         s_val_q   <= '0;
         t7_q      <= '0;
         t8_q      <= '0;
         g_dz_q    <= 1'b0;
         dz_acc_q  <= 1'b0;
         s_buf_q   <= '0;
         l_buf_q   <= '0;
         dz_buf_q  <= '0;
         s_out_q   <= '0;
         l_out_q   <= '0;
         div0_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         p_sh_q    <= p_sh_d;
         g_sh_q    <= g_sh_d;
         r_sh_q    <= r_sh_d;
         u_sh_q    <= u_sh_d;
         c_sh_q    <= c_sh_d;
         t_sh_q    <= t_sh_d;
         qlen_sh_q <= qlen_sh_d;
         m_sh_q    <= m_sh_d;
         w_sh_q    <= w_sh_d;
         a_q       <= a_d;
         b_q       <= b_d;
         e_q       <= e_d;
         s_val_q   <= s_val_d;
         t7_q      <= t7_d;
         t8_q      <= t8_d;
         g_dz_q    <= g_dz_d;
         dz_acc_q  <= dz_acc_d;
         s_buf_q   <= s_buf_d;
         l_buf_q   <= l_buf_d;
         dz_buf_q  <= dz_buf_d;
         s_out_q   <= s_out_d;
         l_out_q   <= l_out_d;
         div0_q    <= div0_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign s       = s_out_q;
   assign l       = l_out_q;
   assign div0    = div0_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: doc/multi_dropoff_station.md
# multi_dropoff_station

Sequential, multi-channel successor to the per-station dropoff logic of the train balancer. One instance serves `CH` resource channels at one physical stop. Each channel has its own queue, capacity and train-load configuration, supplied as runtime inputs rather than build-time constants. On each game-tick strobe the block snapshots all inputs, time-multiplexes one shared iterative divider across the channels, and atomically publishes every channel's S (share of global total) and L (train limit). A one-cycle valid pulse marks the update.

## Interface
- `CH`, 4: number of resource channels.
- `INT`, 31: MSB index of every scalar; scalars are `INT+1` bits, unsigned.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `tick` in 1: start-of-sweep strobe (one game tick).
- `p` in INT+1: precision P (green).
- `g` in INT+1: station count G (green).
- `r` in CH*(INT+1): per-channel global percentage R (red).
- `u` in CH*(INT+1): buffered units U.
- `c` in CH*(INT+1): trains assigned C.
- `t` in CH*(INT+1): train-present T.
- `cfg_q` in CH*(INT+1): queue length Q.
- `cfg_m` in CH*(INT+1): capacity M.
- `cfg_w` in CH*(INT+1): units per train W.
- `s` out CH*(INT+1): contribution S (red).
- `l` out CH*(INT+1): train limit L.
- `valid` out 1: one-cycle pulse; `s`/`l` were just updated.
- `busy` out 1: sweep in progress.
- `overrun` out 1: one-cycle pulse; a tick arrived while busy.
- `div0` out CH: per-channel divide-by-zero seen in the last sweep.
- Channel k occupies bits [k*(INT+1) +: INT+1].

## Operation
- FSM states: IDLE, CALC, DIV_S, DIV_T7, DIV_T8, COMMIT, DONE.
- IDLE + `tick`:
  - snapshot all inputs into shadow registers;
  - channel index = 0;
  - go to CALC.
- CALC computes:
  - t0 = (T≠0);
  - Z = C−t0, clamped at 0;
  - A = U + Z·W, truncated to INT+1;
  - b = (A<M) && (M−A ≥ W);
  - e = (C<Q);
  - PA = A·P, 2(INT+1) bits.
- DIV_S: S = PA / M.
- DIV_T7: t7 = (R·P) / G.
- DIV_T8: t8 = t7 / P.
- All quotients saturate to 2^(INT+1)−1.
- COMMIT:
  - d = (S ≤ t8);
  - L = C + (b&&d&&e), truncated;
  - write S and L to the channel's result buffer;
  - if the index is not the last, increment it and go to CALC; otherwise go to DONE.
- DONE:
  - copy all result buffers to `s`/`l` together;
  - pulse `valid`;
  - return to IDLE.
- Divide-by-zero:
  - M=0 gives S=0; G=0 forces d=0; P=0 gives t8=0.
  - Each case sets `div0[k]` for that sweep.
  - `div0` updates together with `s`/`l` at DONE.
- `tick` while not IDLE is ignored, pulses `overrun`, and does not disturb the sweep.
- Inputs changing mid-sweep have no effect; only the snapshot is used.
- Reset clears the FSM (to IDLE), `s`, `l`, `div0`, `valid`, `busy`, `overrun` and all buffers to 0.
- Reset mid-sweep abandons the sweep; no `valid` follows.

## Timing
- Divider: 1 load cycle plus 2(INT+1) restoring iterations, giving 2·INT+3 cycles per division.
- Per channel: CALC 1 + 3·(2·INT+3) + COMMIT 1 = 6·INT+11 cycles. With INT=31 that is 197.
- Latency: with the tick sampled at edge k, `valid` is high in cycle k + CH·(6·INT+11) + 1. Defaults give 789.
- `busy` is high from edge k until the edge ending DONE.
- A tick in the DONE cycle is an overrun.
- The earliest tick accepted for the next sweep is in the cycle after DONE.
- Outputs are registered with no combinational input-to-output path.

## Structure
- `train_balancer_pkg` holds:
  - FSM state enum;
  - function `sweep_cycles(CH, INT)`;
  - divide-by-zero and saturation constants.
- Sub-module `seq_divider` takes parameter DW = 2(INT+1).
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient, dz.
  - Fixed 2·INT+3-cycle latency; saturated quotient.
  - Shared by all channels.
- Top level holds the FSM, snapshot and result buffers, and CALC/COMMIT logic.

## Test plan
- Baseline: P=100, G=2, R=100, M=128000, W=8000, Q=3, U=0, C=0, T=0 gives S=0, t8=50 and L=1. `valid` is high exactly 789 cycles after tick.
- Capacity edge: U=120001 (M−A=7999<W) gives L=C. U=120000 gives L=C+1. U=64000, C=0 gives S=50.
- Queue and clamp:
  - C=3, Q=3 gives L=3.
  - C=0, T=1 gives Z=0 (no underflow), A=U.
- Divide-by-zero: G=0 gives L=C and `div0[k]`=1. M=0 gives S=0 and `div0[k]`=1. The other channels are unaffected.
- Overrun: a tick at +100 cycles and a tick in the DONE cycle each pulse `overrun`. `valid` timing and results stay unchanged.
- Reset mid-sweep at +400:
  - all outputs read 0;
  - no `valid` pulse follows;
  - the next tick completes a normal sweep.
